mat_vec_mul: RTL and testbench



---
 rtl/mvm_pkg.sv | 21 ++
 rtl/mvm_dot_product.sv | 57 +++++
 rtl/mat_vec_mul.sv | 30 +++
 tb/tb_mat_vec_mul.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared constants and element type for the matrix-vector multiplier datapath.
// Other accelerator blocks import this to agree on element width and default shape.
package mvm_pkg;

    localparam int unsigned MVM_DATA_WIDTH = 32;
    localparam int unsigned MVM_MAT_ROW    = 4;
    localparam int unsigned MVM_MAT_COL    = 4;

    typedef logic [MVM_DATA_WIDTH-1:0] elem_t;

    // Smallest power of two >= n; sizes the balanced adder tree.
    function automatic int unsigned pow2_ceil(input int unsigned n);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < 32; i++) begin
            if (p < n) p = p << 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/mvm_dot_product.sv
// One row of the matrix-vector product: registered element products feeding
// a balanced combinational adder tree whose sum is registered as the row result.
module mvm_dot_product
    import mvm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MVM_DATA_WIDTH,
    parameter int unsigned MAT_COL    = MVM_MAT_COL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] row [0:MAT_COL-1],
    input  logic [DATA_WIDTH-1:0] vec [0:MAT_COL-1],
    output logic [DATA_WIDTH-1:0] res
);

    localparam int unsigned LEAVES = pow2_ceil(MAT_COL);

    logic [DATA_WIDTH-1:0] prod [0:MAT_COL-1];
    // Heap-ordered tree: node[1] is the root, leaves live at [LEAVES .. 2*LEAVES-1].
    logic [DATA_WIDTH-1:0] node [1:2*LEAVES-1];

    // Stage 1: products truncated to the element width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < int'(MAT_COL); j++) begin
                prod[j] <= '0;
            end
        end else begin
            for (int j = 0; j < int'(MAT_COL); j++) begin
                prod[j] <= row[j] * vec[j];
            end
        end
    end

    // Adder tree; unused leaves are zero-padded so any column count works.
    always_comb begin
        for (int k = 1; k < int'(2 * LEAVES); k++) begin
            node[k] = '0;
        end
        for (int k = 0; k < int'(MAT_COL); k++) begin
            node[int'(LEAVES) + k] = prod[k];
        end
        for (int k = int'(LEAVES) - 1; k >= 1; k--) begin
            node[k] = node[2*k] + node[2*k+1];
        end
    end

    // Stage 2: registered row sum, wrapping modulo 2^DATA_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= '0;
        end else begin
            res <= node[1];
        end
    end

endmodule

// File: rtl/mat_vec_mul.sv
// Pipelined unsigned matrix-vector multiplier, two-cycle latency, one result per cycle.
// Each row is an independent dot-product pipeline.
module mat_vec_mul
    import mvm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = MVM_DATA_WIDTH,
    parameter int unsigned MAT_ROW    = MVM_MAT_ROW,
    parameter int unsigned MAT_COL    = MVM_MAT_COL
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] mat [0:MAT_ROW-1][0:MAT_COL-1],
    input  logic [DATA_WIDTH-1:0] vec [0:MAT_COL-1],
    output logic [DATA_WIDTH-1:0] res [0:MAT_ROW-1]
);

    for (genvar i = 0; i < int'(MAT_ROW); i++) begin : g_row
        mvm_dot_product #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAT_COL    (MAT_COL)
        ) u_dot (
            .clk (clk),
            .rst (rst),
            .row (mat[i]),
            .vec (vec),
            .res (res[i])
        );
    end

endmodule

// File: tb/tb_mat_vec_mul.sv
// Self-checking bench for mat_vec_mul: directed corner cases plus random streaming
// compared against a plain-arithmetic reference model.
module tb_mat_vec_mul;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned NC = 4;

    typedef logic [DW-1:0] mat_t [0:NR-1][0:NC-1];
    typedef logic [DW-1:0] col_t [0:NC-1];
    typedef logic [DW-1:0] row_t [0:NR-1];

    logic clk = 1'b0;
    logic rst;
    mat_t mat;
    col_t vec;
    row_t res;

    int n_pass  = 0;
    int n_total = 0;

    mat_vec_mul #(
        .DATA_WIDTH (DW),
        .MAT_ROW    (NR),
        .MAT_COL    (NC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mat (mat),
        .vec (vec),
        .res (res)
    );

    always #5 clk = ~clk;

    // Reference: full-precision sum of products, reduced modulo 2^DW at the end.
    function automatic row_t model(input mat_t m, input col_t v);
        row_t r;
        logic [63:0] acc;
        for (int i = 0; i < int'(NR); i++) begin
            acc = '0;
            for (int j = 0; j < int'(NC); j++) begin
                acc = acc + 64'(m[i][j]) * 64'(v[j]);
            end
            r[i] = acc[DW-1:0];
        end
        return r;
    endfunction

    task automatic check_res(input string tag, input row_t exp);
        for (int i = 0; i < int'(NR); i++) begin
            n_total++;
            assert (res[i] === exp[i]) n_pass++;
            else $error("FAIL %s res[%0d] observed=%h expected=%h", tag, i, res[i], exp[i]);
        end
    endtask

    task automatic drive_random(input int unsigned maxval);
        for (int i = 0; i < int'(NR); i++)
            for (int j = 0; j < int'(NC); j++)
                mat[i][j] = (maxval == 0) ? DW'($urandom) : DW'($urandom_range(0, maxval));
        for (int j = 0; j < int'(NC); j++)
            vec[j] = (maxval == 0) ? DW'($urandom) : DW'($urandom_range(0, maxval));
    endtask

    task automatic drive_fill(input logic [DW-1:0] mval, input logic [DW-1:0] vval);
        for (int i = 0; i < int'(NR); i++)
            for (int j = 0; j < int'(NC); j++)
                mat[i][j] = mval;
        for (int j = 0; j < int'(NC); j++)
            vec[j] = vval;
    endtask

    row_t zero;
    row_t exp_r;
    row_t hist [$];

    initial begin
        zero = '{default: '0};

        // Reset with nonzero inputs: outputs clear immediately and stay clear.
        rst = 1'b1;
        drive_fill(32'h1234_5677, 32'h0000_0003);
        #1 check_res("reset_async", zero);
        repeat (3) @(negedge clk);
        check_res("reset_held", zero);

        // Identity with vec = 1..4, released from reset.
        drive_fill('0, '0);
        for (int i = 0; i < int'(NR); i++) mat[i][i] = 32'd1;
        for (int j = 0; j < int'(NC); j++) vec[j] = DW'(j + 1);
        @(negedge clk);
        check_res("reset_held_ident", zero);
        rst = 1'b0;
        @(negedge clk);
        check_res("release_first_edge", zero);
        @(negedge clk);
        exp_r = '{32'd1, 32'd2, 32'd3, 32'd4};
        check_res("identity", exp_r);

        // Max 8-bit values; previous result must persist for exactly one more edge.
        drive_fill(32'd255, 32'd255);
        @(negedge clk);
        check_res("max8_latency", exp_r);
        @(negedge clk);
        exp_r = '{default: 32'd260100};
        check_res("max8", exp_r);
        @(negedge clk);
        check_res("max8_held", exp_r);

        // Product truncation and accumulation wrap.
        drive_fill('0, '0);
        mat[0][0] = 32'hFFFF_FFFF;
        vec[0]    = 32'd2;
        repeat (2) @(negedge clk);
        exp_r = '{32'hFFFF_FFFE, 32'd0, 32'd0, 32'd0};
        check_res("wrap_product", exp_r);
        mat[0][1] = 32'd3;
        vec[1]    = 32'd1;
        @(negedge clk);
        check_res("wrap_latency", exp_r);
        @(negedge clk);
        exp_r = '{32'h0000_0001, 32'd0, 32'd0, 32'd0};
        check_res("wrap_sum", exp_r);

        // Back-to-back random 8-bit pairs, each result exactly two edges later.
        for (int c = 0; c < 12; c++) begin
            if (c >= 2) check_res($sformatf("stream%0d", c - 2), hist[c-2]);
            if (c < 10) begin
                drive_random(255);
                hist.push_back(model(mat, vec));
            end
            @(negedge clk);
        end

        // Full-range random stream, then an async reset pulse between edges.
        hist.delete();
        for (int c = 0; c < 4; c++) begin
            if (c >= 2) check_res($sformatf("full%0d", c - 2), hist[c-2]);
            drive_random(0);
            hist.push_back(model(mat, vec));
            @(negedge clk);
        end
        drive_random(0);
        exp_r = model(mat, vec);
        #2 rst = 1'b1;
        #1 check_res("midrst_async", zero);
        #1 rst = 1'b0;
        @(negedge clk);
        check_res("midrst_flush", zero);
        @(negedge clk);
        check_res("midrst_resume", exp_r);
        @(negedge clk);
        check_res("midrst_held", exp_r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
